// File: rtl/dds_sweep_if.sv
// Handshake and data bundle between a sweep requester and dds_sweep_controller.
// The master side drives the sweep request and its configuration; the slave side returns the increment and status pulses.
interface dds_sweep_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic               continuous;
    logic [31:0]        start_step;
    logic [31:0]        stop_step;
    logic [31:0]        delta;
    logic [DWELL_W-1:0] dwell;
    logic [31:0]        phase_step;
    logic               acc_clear;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
        output start, abort, continuous, start_step, stop_step, delta, dwell,
        input  phase_step, acc_clear, busy, done, wrap
    );

    modport slave (
        input  start, abort, continuous, start_step, stop_step, delta, dwell,
        output phase_step, acc_clear, busy, done, wrap
    );
endinterface

// File: rtl/dds_sweep_controller.sv
// Linear frequency sweep generator for a DDS phase accumulator: steps the phase
// increment from start_step towards stop_step by delta, holding each value for dwell+1 cycles.
module dds_sweep_controller #(
    parameter int DWELL_W = 16
) (
    input logic        clk,
    input logic        reset_n,
    dds_sweep_if.slave sif
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        phase_step_q, phase_step_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [31:0]        start_q, start_d;
    logic [31:0]        stop_q, stop_d;
    logic [31:0]        delta_q, delta_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q, cont_d;
    logic               acc_clear_q, acc_clear_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [32:0]        next_step;

    // The carry bit of next_step counts as overshooting stop_step, so the increment never wraps.
    assign next_step = {1'b0, phase_step_q} + {1'b0, delta_q};

    always_comb begin
        state_d      = state_q;
        phase_step_d = phase_step_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        stop_d       = stop_q;
        delta_d      = delta_q;
        dwell_d      = dwell_q;
        cont_d       = cont_q;
        acc_clear_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        wrap_d       = 1'b0;

        if (sif.abort) begin
            state_d      = IDLE;
            phase_step_d = '0;
            cnt_d        = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.start) begin
                        start_d      = sif.start_step;
                        stop_d       = sif.stop_step;
                        delta_d      = sif.delta;
                        dwell_d      = sif.dwell;
                        cont_d       = sif.continuous;
                        phase_step_d = sif.start_step;
                        cnt_d        = sif.dwell;
                        acc_clear_d  = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = DWELL;
                    end
                end
                DWELL: begin
                    busy_d = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
                    end else if (!next_step[32] && (next_step[31:0] <= stop_q)) begin
                        phase_step_d = next_step[31:0];
                        cnt_d        = dwell_q;
                    end else if (cont_q) begin
                        phase_step_d = start_q;
                        cnt_d        = dwell_q;
                        wrap_d       = 1'b1;
                        acc_clear_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            phase_step_q <= '0;
            cnt_q        <= '0;
            start_q      <= '0;
            stop_q       <= '0;
            delta_q      <= '0;
            dwell_q      <= '0;
            cont_q       <= 1'b0;
            acc_clear_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_step_q <= phase_step_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            delta_q      <= delta_d;
            dwell_q      <= dwell_d;
            cont_q       <= cont_d;
            acc_clear_q  <= acc_clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wrap_q       <= wrap_d;
        end
    end

    assign sif.phase_step = phase_step_q;
    assign sif.acc_clear  = acc_clear_q;
    assign sif.busy       = busy_q;
    assign sif.done       = done_q;
    assign sif.wrap       = wrap_q;
endmodule

// File: tb/tb_dds_sweep_controller.sv
// Randomized and directed bench for dds_sweep_controller against a step-list reference model.
module tb_dds_sweep_controller;
    localparam int DWELL_W = 16;
    localparam int MAXC    = 48;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] e_ps   [MAXC];
    bit          e_busy [MAXC];
    bit          e_clr  [MAXC];
    bit          e_wrap [MAXC];
    bit          e_done [MAXC];

    dds_sweep_if #(.DWELL_W(DWELL_W)) sif ();

    dds_sweep_controller #(.DWELL_W(DWELL_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sif     (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".ps"},   {32'b0, sif.phase_step}, 64'd0);
        chk({tag, ".busy"}, {63'b0, sif.busy},       64'd0);
        chk({tag, ".clr"},  {63'b0, sif.acc_clear},  64'd0);
        chk({tag, ".done"}, {63'b0, sif.done},       64'd0);
        chk({tag, ".wrap"}, {63'b0, sif.wrap},       64'd0);
    endtask

    // Expected per-cycle outputs, index 0 = the cycle right after the start edge.
    task automatic build(input logic [31:0] s, input logic [31:0] st, input logic [31:0] d,
                         input int dw, input bit cont);
        longint v, nx;
        int     pos;
        bit     fresh, wr, finished;
        v = {32'b0, s};
        pos = 0;
        fresh = 1'b1;
        wr = 1'b0;
        finished = 1'b0;
        while (pos < MAXC && !finished) begin
            for (int r = 0; r <= dw && pos < MAXC; r++) begin
                e_ps[pos]   = v[31:0];
                e_busy[pos] = 1'b1;
                e_clr[pos]  = (r == 0) && fresh;
                e_wrap[pos] = (r == 0) && wr;
                e_done[pos] = 1'b0;
                pos++;
            end
            nx = v + {32'b0, d};
            if (nx > {32'b0, st}) begin
                if (cont) begin
                    v = {32'b0, s};
                    fresh = 1'b1;
                    wr = 1'b1;
                end else begin
                    for (int k = pos; k < MAXC; k++) begin
                        e_ps[k]   = v[31:0];
                        e_busy[k] = 1'b0;
                        e_clr[k]  = 1'b0;
                        e_wrap[k] = 1'b0;
                        e_done[k] = (k == pos);
                    end
                    finished = 1'b1;
                end
            end else begin
                v = nx;
                fresh = 1'b0;
                wr = 1'b0;
            end
        end
    endtask

    task automatic drive_cfg(input logic [31:0] s, input logic [31:0] st, input logic [31:0] d,
                             input int dw, input bit cont);
        sif.start_step = s;
        sif.stop_step  = st;
        sif.delta      = d;
        sif.dwell      = DWELL_W'(dw);
        sif.continuous = cont;
    endtask

    // Starts a sweep, checks ncyc cycles, then aborts and checks the forced idle state.
    task automatic run(input string name, input logic [31:0] s, input logic [31:0] st,
                       input logic [31:0] d, input int dw, input bit cont,
                       input int ncyc, input bit garbage);
        string tg;
        build(s, st, d, dw, cont);
        @(negedge clk);
        drive_cfg(s, st, d, dw, cont);
        sif.abort = 1'b0;
        sif.start = 1'b1;
        for (int j = 0; j < ncyc; j++) begin
            @(negedge clk);
            tg = $sformatf("%s[%0d]", name, j);
            chk({tg, ".ps"},   {32'b0, sif.phase_step}, {32'b0, e_ps[j]});
            chk({tg, ".busy"}, {63'b0, sif.busy},       {63'b0, e_busy[j]});
            chk({tg, ".clr"},  {63'b0, sif.acc_clear},  {63'b0, e_clr[j]});
            chk({tg, ".wrap"}, {63'b0, sif.wrap},       {63'b0, e_wrap[j]});
            chk({tg, ".done"}, {63'b0, sif.done},       {63'b0, e_done[j]});
            if (garbage) begin
                drive_cfg($urandom, $urandom, $urandom, int'($urandom_range(0, 7)), 1'($urandom));
                sif.start = (e_busy[j] || e_done[j]) ? 1'($urandom) : 1'b0;
            end else begin
                sif.start = 1'b0;
            end
        end
        sif.abort = 1'b1;
        @(negedge clk);
        chk_idle_zero({name, ".abort"});
        sif.abort = 1'b0;
        sif.start = 1'b0;
    endtask

    initial begin
        sif.start = 1'b0;
        sif.abort = 1'b0;
        drive_cfg(32'd0, 32'd0, 32'd0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_idle_zero("post_reset");

        run("single",   32'd100, 32'd250, 32'd50, 0, 1'b0, 8,  1'b0);
        run("dwell3",   32'd100, 32'd250, 32'd50, 3, 1'b0, 20, 1'b0);
        run("contwrap", 32'd10,  32'd30,  32'd10, 0, 1'b1, 8,  1'b0);
        run("overflow", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 1'b0, 4, 1'b0);
        run("ovf_dw2",  32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 2, 1'b1, 9, 1'b0);
        run("delta0",   32'd77,  32'd500, 32'd0,  1, 1'b0, 12, 1'b0);
        run("inverted", 32'd900, 32'd100, 32'd5,  2, 1'b0, 6,  1'b0);
        run("abort2nd", 32'd100, 32'd250, 32'd50, 0, 1'b0, 2,  1'b0);
        @(negedge clk);
        chk_idle_zero("abort2nd.after");
        run("busystart", 32'd100, 32'd250, 32'd50, 3, 1'b0, 20, 1'b1);

        // abort wins over a simultaneous start in IDLE
        drive_cfg(32'd123, 32'd999, 32'd1, 0, 1'b0);
        sif.start = 1'b1;
        sif.abort = 1'b1;
        @(negedge clk);
        chk_idle_zero("abort_start");
        sif.start = 1'b0;
        sif.abort = 1'b0;
        @(negedge clk);
        chk_idle_zero("abort_start.after");

        // asynchronous reset in the middle of a sweep
        drive_cfg(32'd100, 32'd250, 32'd50, 1, 1'b0);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mid.busy_before", {63'b0, sif.busy}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk_idle_zero("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_zero("rst_mid.after");

        for (int it = 0; it < 30; it++) begin
            logic [31:0] s, st, d;
            if (it % 5 == 4) begin
                s  = 32'hFFFF_FF00 + $urandom_range(0, 255);
                st = 32'hFFFF_FF00 + $urandom_range(0, 255);
                d  = $urandom_range(0, 128);
            end else begin
                s  = $urandom_range(0, 1000);
                st = $urandom_range(0, 1200);
                d  = $urandom_range(0, 200);
            end
            run($sformatf("rnd%0d", it), s, st, d, int'($urandom_range(0, 3)),
                1'($urandom), 40, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
